// File: rtl/uart_rx_fifo_param_if.sv
// uart_rx_fifo_param_if: serial line plus host-side FIFO signals of the UART receiver
interface uart_rx_fifo_param_if #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
);
  logic                   rx;
  logic                   rd_en;
  logic                   clr_ovr;
  logic [DATA_BITS-1:0]   data;
  logic                   perr;
  logic                   ferr;
  logic                   data_rdy;
  logic                   overrun;
  logic [$clog2(DEPTH):0] count;
  logic                   busy;
  modport master (output rx, rd_en, clr_ovr,
                  input  data, perr, ferr, data_rdy, overrun, count, busy);
  modport slave  (input  rx, rd_en, clr_ovr,
                  output data, perr, ferr, data_rdy, overrun, count, busy);
endinterface

// File: rtl/uart_rx_fifo_param.sv
// uart_rx_fifo_param: oversampling UART receiver feeding a first-word-fall-through FIFO
module uart_rx_fifo_param #(
  parameter int CLK_DIV   = 27,
  parameter int OS        = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  uart_rx_fifo_param_if.slave bus
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(OS);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [SW-1:0] S_M1  = SW'(OS/2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OS/2);
  localparam logic [SW-1:0] S_M2  = SW'(OS/2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OS - 1);
  localparam logic [3:0] N_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] N_STOP = 4'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t               state_q, state_d;
  logic                 rx_s1_q, rx_q;
  logic [DW-1:0]        div_q, div_d;
  logic [SW-1:0]        s_q, s_d;
  logic [3:0]           n_q, n_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [1:0]           v_q, v_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 tick, maj, push;
  logic [DATA_BITS+1:0] mem [DEPTH];
  logic [DATA_BITS+1:0] head;
  logic [AW-1:0]        wp_q, rp_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovr_q, ovr_d;
  logic                 full, pop, wr, ovr_set;
  assign tick  = div_q == DW'(CLK_DIV - 1);
  assign div_d = tick ? '0 : div_q + 1'b1;
  // v_q holds the two earlier samples; the third is the live line value
  assign maj = (v_q[0] & v_q[1]) | (v_q[0] & rx_q) | (v_q[1] & rx_q);
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    v_d     = v_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;
    if (tick) begin
      s_d = s_q == S_END ? '0 : s_q + 1'b1;
      if (s_q == S_M1 || s_q == S_MID) v_d = {v_q[0], rx_q};
      case (state_q)
        IDLE: begin
          s_d = '0;
          if (!rx_q) begin
            state_d = START;
            n_d     = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
        START: state_d = (s_q == S_MID && rx_q) ? IDLE : (s_q == S_END) ? DATA : START;
        DATA: begin
          if (s_q == S_M2) sh_d = {maj, sh_q[DATA_BITS-1:1]};
          if (s_q == S_END) begin
            n_d     = n_q == N_DATA ? '0 : n_q + 1'b1;
            state_d = n_q != N_DATA ? DATA : PARITY != 0 ? PAR : STOP;
          end
        end
        PAR: begin
          if (s_q == S_M2) perr_d = ((^sh_q) ^ maj) != (PARITY == 2);
          if (s_q == S_END) state_d = STOP;
        end
        STOP: begin
          if (s_q == S_M2) begin
            ferr_d = ferr_q | ~maj;
            if (n_q == N_STOP) begin
              push    = 1'b1;
              state_d = IDLE;
            end
          end else if (s_q == S_END) n_d = n_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign full    = cnt_q == CW'(DEPTH);
  assign pop     = bus.rd_en && cnt_q != '0;
  assign wr      = push && (!full || pop);
  assign ovr_set = push && full && !pop;
  assign cnt_d   = cnt_q + CW'(wr) - CW'(pop);
  assign ovr_d   = ovr_set ? 1'b1 : bus.clr_ovr ? 1'b0 : ovr_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1_q <= 1'b1;
      rx_q    <= 1'b1;
      div_q   <= '0;
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      v_q     <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      rx_s1_q <= bus.rx;
      rx_q    <= rx_s1_q;
      div_q   <= div_d;
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      v_q     <= v_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      wp_q    <= wr ? wp_q + 1'b1 : wp_q;
      rp_q    <= pop ? rp_q + 1'b1 : rp_q;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end
  // The stop bit being sampled now is folded straight into the stored tag
  always_ff @(posedge clk_i) begin
    if (wr) mem[wp_q] <= {ferr_q | ~maj, perr_q, sh_q};
  end
  assign head         = mem[rp_q];
  assign bus.data_rdy = cnt_q != '0;
  assign bus.data     = bus.data_rdy ? head[DATA_BITS-1:0] : '0;
  assign bus.perr     = bus.data_rdy & head[DATA_BITS];
  assign bus.ferr     = bus.data_rdy & head[DATA_BITS+1];
  assign bus.overrun  = ovr_q;
  assign bus.count    = cnt_q;
  assign bus.busy     = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// tb_uart_rx_fifo_param: directed frames into three receiver configurations (no parity, even, odd + 2 stop)
module tb_uart_rx_fifo_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  uart_rx_fifo_param_if #(.DATA_BITS(8), .DEPTH(4)) ia ();
  uart_rx_fifo_param_if #(.DATA_BITS(8), .DEPTH(4)) ib ();
  uart_rx_fifo_param_if #(.DATA_BITS(8), .DEPTH(4)) ic ();
  uart_rx_fifo_param #(.CLK_DIV(2), .OS(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4))
    dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ia));
  uart_rx_fifo_param #(.CLK_DIV(2), .OS(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DEPTH(4))
    dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ib));
  uart_rx_fifo_param #(.CLK_DIV(2), .OS(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .DEPTH(4))
    dut_c (.clk_i(clk), .rst_ni(rst_n), .bus(ic));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // bits are sent LSB first, one bit time (32 clk) each, line returns high afterwards
  task automatic send(input int u, input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      case (u)
        0: ia.rx = b[i];
        1: ib.rx = b[i];
        default: ic.rx = b[i];
      endcase
      repeat (32) @(negedge clk);
    end
    ia.rx = 1'b1;
    ib.rx = 1'b1;
    ic.rx = 1'b1;
  endtask
  task automatic pop(input int u);
    @(negedge clk);
    case (u)
      0: ia.rd_en = 1'b1;
      1: ib.rd_en = 1'b1;
      default: ic.rd_en = 1'b1;
    endcase
    @(negedge clk);
    ia.rd_en = 1'b0;
    ib.rd_en = 1'b0;
    ic.rd_en = 1'b0;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    ia.rx = 1'b1; ia.rd_en = 1'b0; ia.clr_ovr = 1'b0;
    ib.rx = 1'b1; ib.rd_en = 1'b0; ib.clr_ovr = 1'b0;
    ic.rx = 1'b1; ic.rd_en = 1'b0; ic.clr_ovr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset data_rdy", ia.data_rdy, 0);
    check("reset count", ia.count, 0);
    check("reset busy", ia.busy, 0);
    check("reset overrun", ia.overrun, 0);
    check("reset data", ia.data, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    // basic frame 0x55
    send(0, 16'b1_01010101_0, 10);
    repeat (4) @(negedge clk);
    check("t1 data_rdy", ia.data_rdy, 1);
    check("t1 data", ia.data, 8'h55);
    check("t1 perr", ia.perr, 0);
    check("t1 ferr", ia.ferr, 0);
    check("t1 count", ia.count, 1);
    pop(0);
    check("t1 empty after pop", ia.data_rdy, 0);
    check("t1 count after pop", ia.count, 0);
    // 10-clk low glitch must be rejected
    ia.rx = 1'b0;
    repeat (10) @(negedge clk);
    check("t2 busy during glitch", ia.busy, 1);
    ia.rx = 1'b1;
    repeat (60) @(negedge clk);
    check("t2 busy after glitch", ia.busy, 0);
    check("t2 count after glitch", ia.count, 0);
    // even parity: 0xA3 has 4 ones
    send(1, 16'b1_1_10100011_0, 11);
    send(1, 16'b1_0_10100011_0, 11);
    repeat (4) @(negedge clk);
    check("t3 even count", ib.count, 2);
    check("t3 even p1 data", ib.data, 8'hA3);
    check("t3 even p1 perr", ib.perr, 1);
    pop(1);
    check("t3 even p0 perr", ib.perr, 0);
    check("t3 even p0 ferr", ib.ferr, 0);
    pop(1);
    // odd parity with two stop bits
    send(2, 16'b11_1_10100011_0, 12);
    send(2, 16'b11_0_10100011_0, 12);
    repeat (4) @(negedge clk);
    check("t3 odd count", ic.count, 2);
    check("t3 odd p1 perr", ic.perr, 0);
    check("t3 odd p1 ferr", ic.ferr, 0);
    pop(2);
    check("t3 odd p0 data", ic.data, 8'hA3);
    check("t3 odd p0 perr", ic.perr, 1);
    pop(2);
    // bad stop bit, then an idle gap so the held-low line is rejected as a glitch
    send(0, 16'b0_00111100_0, 10);
    repeat (64) @(negedge clk);
    send(0, 16'b1_10000001_0, 10);
    repeat (4) @(negedge clk);
    check("t4 count", ia.count, 2);
    check("t4 bad data", ia.data, 8'h3C);
    check("t4 bad ferr", ia.ferr, 1);
    pop(0);
    check("t4 good data", ia.data, 8'h81);
    check("t4 good ferr", ia.ferr, 0);
    pop(0);
    check("t4 empty", ia.data_rdy, 0);
    // overrun with DEPTH=4
    for (int i = 1; i <= 5; i++) send(0, {6'b0, 1'b1, 8'(i), 1'b0}, 10);
    repeat (4) @(negedge clk);
    check("t5 count full", ia.count, 4);
    check("t5 overrun", ia.overrun, 1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t5 read %0d", i), ia.data, i);
      pop(0);
    end
    check("t5 drained", ia.data_rdy, 0);
    check("t5 overrun held", ia.overrun, 1);
    @(negedge clk) ia.clr_ovr = 1'b1;
    @(negedge clk) ia.clr_ovr = 1'b0;
    check("t5 overrun cleared", ia.overrun, 0);
    // reset mid frame with words queued
    send(0, 16'b1_00010001_0, 10);
    send(0, 16'b1_00100010_0, 10);
    repeat (4) @(negedge clk);
    check("t6 count before", ia.count, 2);
    send(0, 16'b0101, 4);
    check("t6 busy mid frame", ia.busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6 data_rdy in reset", ia.data_rdy, 0);
    check("t6 count in reset", ia.count, 0);
    check("t6 busy in reset", ia.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send(0, 16'b1_11110000_0, 10);
    repeat (4) @(negedge clk);
    check("t6 count after", ia.count, 1);
    check("t6 data after", ia.data, 8'hF0);
    check("t6 ferr after", ia.ferr, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
